address_issue_writeback: RTL and testbench
==========================================

// Module: address_issue_writeback
// PURPOSE
//  Issue and writeback stage wrapped around address_sum_diff (32-bit Ai = Aj +/- Ak, no overflow).
//  - Holds the eight 32-bit A registers.
//  - Issues opcode 020/021 instructions to the adder; the adder has no valid signal.
//  - Tracks in-flight destinations in a valid/dest shift pipe.
//  - Writes i_Ai back to A[i] at a fixed latency.
//  - Stalls issue on RAW/WAW hazards through per-register reservation bits.
// PARAMETERS
//  WIDTH    32  A register / datapath width
//  NREG     8   number of A registers (index width 3)
//  LATENCY  6   edges from issue edge to writeback edge (1 operand reg + 5 adder stages)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      synchronous reset, active-high
//  i_valid        in   1      instruction offered
//  i_Instr        in   7      opcode (octal 020 add, 021 subtract)
//  i_i            in   3      destination register index
//  i_j            in   3      first operand index
//  i_k            in   3      second operand index
//  o_ready        out  1      issue accepted this cycle when i_valid & o_ready
//  o_illegal      out  1      one-cycle pulse: accepted opcode was not 020/021, dropped
//  o_Aj           out  WIDTH  operand to adder i_Aj (registered)
//  o_Ak           out  WIDTH  operand to adder i_Ak (registered)
//  o_Instr        out  7      opcode to adder i_Instr (registered; 0 when idle)
//  o_issue_valid  out  1      o_Aj/o_Ak/o_Instr carry a real op this cycle
//  i_Ai           in   WIDTH  result from adder o_Ai
//  i_ld_en        in   1      external load request (init/test)
//  i_ld_addr      in   3      load target index
//  i_ld_data      in   WIDTH  load value
//  o_ld_ready     out  1      load accepted when i_ld_en & o_ld_ready
//  i_rd_addr      in   3      debug read index
//  o_rd_data      out  WIDTH  A[i_rd_addr], combinational
//  o_busy         out  1      any reservation bit set
// BEHAVIOUR
//  Reset (rst=1 at an edge): applies to all state; rst has priority over everything.
//  - A[0..7]=0, reservations=0, pipe valid bits=0.
//  - o_Aj=o_Ak=0, o_Instr=0, o_issue_valid=0, o_illegal=0.
//  - In-flight results are discarded: no writeback occurs for ops issued before the reset.
//  - Combinational outputs settle to: o_ready=1, o_ld_ready=1, o_busy=0.
//  Hazard / o_ready (combinational):
//  - o_ready = !res[i_i] & !res[i_j] & !res[i_k].
//  - A reservation clearing on this edge does not count as free: a dependent op issues
//    the cycle after writeback. No bypass.
//  Issue at edge E0 (i_valid & o_ready):
//  - Legal op: latch o_Aj=A[i_j], o_Ak=A[i_k], o_Instr=i_Instr, o_issue_valid=1;
//    set res[i_i]; push {1,i_i} into the pipe.
//  - Illegal opcode: o_illegal=1 for one cycle; no reservation, no push,
//    o_Instr=0, o_issue_valid=0.
//  - No accepted issue: o_Instr=0, o_issue_valid=0, o_Aj/o_Ak hold, push {0,x}.
//  Writeback:
//  - The pipe entry issued at E0 reaches the tail at edge E0+LATENCY.
//  - At that edge, if valid: A[dest]<=i_Ai and res[dest]<=0.
//  - One issue per cycle max, so exactly one writeback per cycle max; throughput 1/cycle.
//  Same-edge events:
//  - Writeback + issue, same dest: impossible, because res blocks the issue.
//  - Writeback + issue reading that register: the issue waits (see hazard rule).
//  External load:
//  - o_ld_ready = !res[i_ld_addr] & !(writeback valid & dest==i_ld_addr).
//  - Accepted load writes at the edge; operands latched on the same edge see the old value.
//  Arithmetic:
//  - Results are mod 2^WIDTH; wrap-around is legal; no overflow flag.
//  - Block never alters i_Ai.
//  o_busy = |res.
// TESTING
//  Bench instantiates address_sum_diff downstream and uses a reference model with a
//  LATENCY-deep expected queue.
//  1. Load A1=5, A2=7; issue 020 i=3 j=1 k=2 -> o_issue_valid 1 edge after;
//     A3==12 after edge E0+6; o_ready low for i/j/k=3 until then.
//  2. A1=0, A2=1; issue 021 i=4 j=1 k=2 -> A4==32'hFFFFFFFF;
//     A1=32'hFFFFFFFF, A2=1, add -> 0 (wrap).
//  3. Back-to-back independent adds to A3..A7 on consecutive cycles ->
//     five writebacks on five consecutive edges, all correct.
//  4. RAW: add i=3, then add i=4 j=3 k=3 -> second accepted exactly 1 cycle after
//     A3 writeback; A4==2*A3.
//  5. Opcode 7'o017 offered -> o_illegal pulses once; no register changes; o_busy stays 0.
//  6. rst asserted 3 cycles after issue -> all A==0 and o_busy==0;
//     no writeback LATENCY edges later.

Source files
------------

// File: rtl/address_issue_writeback.sv
// Issue/writeback stage for the A-register adder. An issued op writes back LATENCY edges later.
// Stalls o_ready while any register it reads or writes is still reserved; no bypass.
module address_issue_writeback #(
    parameter int WIDTH   = 32,
    parameter int NREG    = 8,
    parameter int LATENCY = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [6:0]       i_Instr,
    input  logic [2:0]       i_i,
    input  logic [2:0]       i_j,
    input  logic [2:0]       i_k,
    output logic             o_ready,
    output logic             o_illegal,
    output logic [WIDTH-1:0] o_Aj,
    output logic [WIDTH-1:0] o_Ak,
    output logic [6:0]       o_Instr,
    output logic             o_issue_valid,
    input  logic [WIDTH-1:0] i_Ai,
    input  logic             i_ld_en,
    input  logic [2:0]       i_ld_addr,
    input  logic [WIDTH-1:0] i_ld_data,
    output logic             o_ld_ready,
    input  logic [2:0]       i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_busy
);

    logic [WIDTH-1:0]   a_q [NREG];
    logic [NREG-1:0]    res_q, res_d;
    logic [LATENCY-1:0] pv_q;
    logic [2:0]         pd_q [LATENCY];
    logic [WIDTH-1:0]   aj_q, ak_q;
    logic [6:0]         instr_q;
    logic               iss_vld_q, ill_q;

    logic       wb_vld;
    logic [2:0] wb_dest;
    logic       issue_acc, legal, push_vld, ld_acc;

    assign wb_vld    = pv_q[LATENCY-1];
    assign wb_dest   = pd_q[LATENCY-1];
    assign legal     = (i_Instr == 7'o020) || (i_Instr == 7'o021);

    // Reservations are checked as registered, so a bit clearing this edge still blocks.
    assign o_ready   = !res_q[i_i] && !res_q[i_j] && !res_q[i_k];
    assign issue_acc = i_valid && o_ready;
    assign push_vld  = issue_acc && legal;

    assign o_ld_ready = !res_q[i_ld_addr] && !(wb_vld && (wb_dest == i_ld_addr));
    assign ld_acc     = i_ld_en && o_ld_ready;

    assign o_rd_data     = a_q[i_rd_addr];
    assign o_busy        = |res_q;
    assign o_Aj          = aj_q;
    assign o_Ak          = ak_q;
    assign o_Instr       = instr_q;
    assign o_issue_valid = iss_vld_q;
    assign o_illegal     = ill_q;

    always_comb begin
        res_d = res_q;
        if (wb_vld)
            res_d[wb_dest] = 1'b0;
        if (push_vld)
            res_d[i_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NREG; n++)
                a_q[n] <= '0;
            for (int n = 0; n < LATENCY; n++)
                pd_q[n] <= '0;
            res_q     <= '0;
            pv_q      <= '0;
            aj_q      <= '0;
            ak_q      <= '0;
            instr_q   <= '0;
            iss_vld_q <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            res_q   <= res_d;
            pv_q    <= {pv_q[LATENCY-2:0], push_vld};
            pd_q[0] <= i_i;
            for (int n = 1; n < LATENCY; n++)
                pd_q[n] <= pd_q[n-1];
            // Load and writeback never target the same register: o_ld_ready excludes it.
            if (wb_vld)
                a_q[wb_dest] <= i_Ai;
            if (ld_acc)
                a_q[i_ld_addr] <= i_ld_data;
            ill_q     <= issue_acc && !legal;
            iss_vld_q <= push_vld;
            instr_q   <= push_vld ? i_Instr : 7'o000;
            if (push_vld) begin
                aj_q <= a_q[i_j];
                ak_q <= a_q[i_k];
            end
        end
    end

endmodule

// File: tb/tb_address_issue_writeback.sv
// Directed bench: a 5-stage adder model sits downstream; a monitor checks issued operands and illegal pulses.
module tb_address_issue_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [6:0]  i_Instr;
    logic [2:0]  i_i, i_j, i_k;
    logic        o_ready, o_illegal, o_issue_valid, o_ld_ready, o_busy;
    logic [31:0] o_Aj, o_Ak, i_Ai, i_ld_data, o_rd_data;
    logic [6:0]  o_Instr;
    logic        i_ld_en;
    logic [2:0]  i_ld_addr, i_rd_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ill_pending = 0;
    logic [70:0] exp_q [$];
    logic [31:0] add_s [5];

    address_issue_writeback dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_Instr(i_Instr),
        .i_i(i_i), .i_j(i_j), .i_k(i_k), .o_ready(o_ready), .o_illegal(o_illegal),
        .o_Aj(o_Aj), .o_Ak(o_Ak), .o_Instr(o_Instr), .o_issue_valid(o_issue_valid),
        .i_Ai(i_Ai), .i_ld_en(i_ld_en), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .o_ld_ready(o_ld_ready), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream adder: five register stages, no valid.
    always @(posedge clk) begin
        add_s[0] <= (o_Instr == 7'o021) ? o_Aj - o_Ak : o_Aj + o_Ak;
        for (int n = 1; n < 5; n++)
            add_s[n] <= add_s[n-1];
    end
    assign i_Ai = add_s[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_issue_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {25'd0, o_Instr}, 32'd0);
            end else begin
                logic [70:0] e;
                e = exp_q.pop_front();
                check("issue_Aj", o_Aj, e[70:39]);
                check("issue_Ak", o_Ak, e[38:7]);
                check("issue_Instr", {25'd0, o_Instr}, {25'd0, e[6:0]});
            end
        end
        if (!rst && o_illegal) begin
            check("illegal_expected", (ill_pending > 0) ? 32'd1 : 32'd0, 32'd1);
            if (ill_pending > 0) ill_pending--;
        end
    end

    task automatic do_load(input logic [2:0] a, input logic [31:0] d);
        bit done = 0;
        i_ld_en = 1'b1; i_ld_addr = a; i_ld_data = d;
        for (int t = 0; t < 60 && !done; t++) begin
            #1;
            if (o_ld_ready) begin
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        i_ld_en = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL load_timeout: addr %0d never accepted", a);
        end
    endtask

    task automatic do_issue(input logic [6:0] op, input logic [2:0] i, input logic [2:0] j,
                            input logic [2:0] k, input logic [31:0] ej, input logic [31:0] ek,
                            output int acc);
        acc = -1;
        i_valid = 1'b1; i_Instr = op; i_i = i; i_j = j; i_k = k;
        for (int t = 0; t < 60 && acc < 0; t++) begin
            #1;
            if (o_ready) begin
                @(posedge clk);
                if (op == 7'o020 || op == 7'o021)
                    exp_q.push_back({ej, ek, op});
                else
                    ill_pending++;
                @(negedge clk);
                acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        i_valid = 1'b0;
        if (acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: op %o dest %0d never accepted", op, i);
        end
    endtask

    task automatic chk_reg(input string nm, input logic [2:0] r, input logic [31:0] exp);
        i_rd_addr = r;
        #1;
        check(nm, o_rd_data, exp);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40 && o_busy; t++)
            @(negedge clk);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, ea, eb, ec, ed;
        int eb3 [5];
        logic [31:0] burst_exp [5];
        rst = 1'b1; i_valid = 1'b0; i_Instr = '0; i_i = '0; i_j = '0; i_k = '0;
        i_ld_en = 1'b0; i_ld_addr = '0; i_ld_data = '0; i_rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_ld_ready", {31'd0, o_ld_ready}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_issue_valid", {31'd0, o_issue_valid}, 32'd0);
        check("rst_Instr", {25'd0, o_Instr}, 32'd0);
        chk_reg("rst_A0", 3'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic add and reservation window
        do_load(3'd1, 32'd5);
        do_load(3'd2, 32'd7);
        do_issue(7'o020, 3'd3, 3'd1, 3'd2, 32'd5, 32'd7, e0);
        i_i = 3'd3; i_j = 3'd0; i_k = 3'd0;
        #1;
        check("t1_busy", {31'd0, o_busy}, 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check("t1_ready_e5", {31'd0, o_ready}, 32'd0);
        chk_reg("t1_A3_e5", 3'd3, 32'd0);
        @(negedge clk);
        #1;
        check("t1_ready_e6", {31'd0, o_ready}, 32'd1);
        chk_reg("t1_A3_e6", 3'd3, 32'd12);
        check("t1_busy_e6", {31'd0, o_busy}, 32'd0);

        // 2: subtract underflow and add wrap
        do_load(3'd1, 32'd0);
        do_load(3'd2, 32'd1);
        do_issue(7'o021, 3'd4, 3'd1, 3'd2, 32'd0, 32'd1, e1);
        wait_idle();
        chk_reg("t2_sub_wrap", 3'd4, 32'hFFFF_FFFF);
        do_load(3'd1, 32'hFFFF_FFFF);
        do_issue(7'o020, 3'd5, 3'd1, 3'd2, 32'hFFFF_FFFF, 32'd1, e1);
        wait_idle();
        chk_reg("t2_add_wrap", 3'd5, 32'd0);

        // 3: back-to-back independent ops, A1=10 A2=3 A0=0
        do_load(3'd1, 32'd10);
        do_load(3'd2, 32'd3);
        do_issue(7'o020, 3'd3, 3'd1, 3'd2, 32'd10, 32'd3,  eb3[0]);
        do_issue(7'o021, 3'd4, 3'd1, 3'd2, 32'd10, 32'd3,  eb3[1]);
        do_issue(7'o020, 3'd5, 3'd1, 3'd1, 32'd10, 32'd10, eb3[2]);
        do_issue(7'o020, 3'd6, 3'd2, 3'd2, 32'd3,  32'd3,  eb3[3]);
        do_issue(7'o020, 3'd7, 3'd1, 3'd0, 32'd10, 32'd0,  eb3[4]);
        check("t3_consecutive", eb3[4] - eb3[0], 32'd4);
        burst_exp[0] = 32'd13; burst_exp[1] = 32'd7; burst_exp[2] = 32'd20;
        burst_exp[3] = 32'd6;  burst_exp[4] = 32'd10;
        @(negedge clk);
        chk_reg("t3_A3_before", 3'd3, 32'd12);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk_reg("t3_burst_wb", 3'(3 + n), burst_exp[n]);
        end
        check("t3_busy_after", {31'd0, o_busy}, 32'd0);

        // 4: RAW dependency issues the cycle after writeback
        do_load(3'd1, 32'd20);
        do_issue(7'o020, 3'd3, 3'd1, 3'd2, 32'd20, 32'd3, ea);
        do_issue(7'o020, 3'd4, 3'd3, 3'd3, 32'd23, 32'd23, eb);
        check("t4_raw_delay", eb - ea, 32'd7);
        wait_idle();
        chk_reg("t4_A3", 3'd3, 32'd23);
        chk_reg("t4_A4", 3'd4, 32'd46);

        // 5: illegal opcode is dropped
        do_issue(7'o017, 3'd5, 3'd1, 3'd2, 32'd0, 32'd0, ec);
        check("t5_busy", {31'd0, o_busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk_reg("t5_A5_unchanged", 3'd5, 32'd20);

        // 6: reset kills an in-flight op
        do_issue(7'o020, 3'd6, 3'd1, 3'd2, 32'd20, 32'd3, ed);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++)
            chk_reg("t6_rst_A", 3'(n), 32'd0);
        check("t6_busy", {31'd0, o_busy}, 32'd0);
        check("t6_ready", {31'd0, o_ready}, 32'd1);
        repeat (8) @(negedge clk);
        chk_reg("t6_no_wb", 3'd6, 32'd0);

        check("leftover_issues", exp_q.size(), 32'd0);
        check("leftover_illegal", ill_pending, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
